// File: rtl/msx_mapper_bank_pkg.sv
// Shared definitions for the MSX memory-mapper bank: limits, FSM states,
// the segment-change notification record and the segment mask helper.
package msx_mapper_bank_pkg;

  localparam int unsigned MAX_CHANNELS = 8;
  localparam int unsigned PAGES        = 4;
  // Widest segment register supported (data_in is one byte).
  localparam int unsigned MAX_SEG_W    = 8;
  // size_log2 is a 4-bit field, so the mask is computed wide enough for 15.
  localparam int unsigned MASK_W       = 16;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StCommit,
    StNotify
  } map_state_e;

  typedef struct packed {
    logic [2:0]           ch;
    logic [1:0]           page;
    logic [MAX_SEG_W-1:0] seg;
  } upd_t;

  // 2^l2 - 1
  function automatic logic [MASK_W-1:0] mask_of(input logic [3:0] l2);
    logic [MASK_W:0] one_hot;
    one_hot     = '0;
    one_hot[l2] = 1'b1;
    return MASK_W'(one_hot - (MASK_W + 1)'(1));
  endfunction

endpackage

// File: rtl/msx_mapper_bank_if.sv
// CPU IO bus, memory-side lookup and segment-change notification signals
// of the mapper bank. master = CPU/host side, slave = mapper bank.
interface msx_mapper_bank_if #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned SEG_W    = 8
);

  logic                     io_en;
  logic                     rd;
  logic                     wr;
  logic [15:0]              addr;
  logic [7:0]               data_in;
  logic [CHANNELS-1:0]      ch_sel;
  logic [CHANNELS-1:0][3:0] size_log2;
  logic [2:0]               mem_ch;
  logic [SEG_W-1:0]         seg_out;
  logic [7:0]               q;
  logic                     output_rq;
  logic                     upd_valid;
  logic                     upd_ready;
  logic [2:0]               upd_ch;
  logic [1:0]               upd_page;
  logic [SEG_W-1:0]         upd_seg;
  logic                     busy;

  modport master (
    output io_en, rd, wr, addr, data_in, ch_sel, size_log2, mem_ch, upd_ready,
    input  seg_out, q, output_rq, upd_valid, upd_ch, upd_page, upd_seg, busy
  );

  modport slave (
    input  io_en, rd, wr, addr, data_in, ch_sel, size_log2, mem_ch, upd_ready,
    output seg_out, q, output_rq, upd_valid, upd_ch, upd_page, upd_seg, busy
  );

endinterface

// File: rtl/msx_mapper_chan.sv
// One mapper channel: four page segment registers, write-strobe edge
// detector with a one-cycle commit delay, live size mask and readback.
module msx_mapper_chan
  import msx_mapper_bank_pkg::*;
#(
  parameter int unsigned SEG_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hit_i,        // ch_sel & io_en & wr
  input  logic             strobe_en_i,  // low while the bank initialises
  input  logic             init_load_i,
  input  logic [1:0]       io_page_i,
  input  logic [SEG_W-1:0] wr_data_i,
  input  logic [3:0]       size_log2_i,
  input  logic [1:0]       mem_page_i,
  output logic             cmt_o,
  output logic [1:0]       cmt_page_o,
  output logic [SEG_W-1:0] cmt_seg_o,
  output logic [7:0]       rd_data_o,
  output logic [SEG_W-1:0] seg_o
);

  logic [MASK_W-1:0]           mask_full;
  logic [SEG_W-1:0]            mask;
  logic                        unused_mask;
  logic                        hit_q, hit_d;
  logic                        pend_q, pend_d;
  logic [1:0]                  pend_page_q, pend_page_d;
  logic [SEG_W-1:0]            pend_data_q, pend_data_d;
  logic [PAGES-1:0][SEG_W-1:0] regs_q, regs_d;

  // Mask follows size_log2 live; stored bits above it are kept but hidden.
  always_comb begin
    mask_full = mask_of(size_log2_i);
    mask      = mask_full[SEG_W-1:0];
  end

  assign unused_mask = ^mask_full;

  // Edge detect, strobe capture and register write (init load or commit).
  always_comb begin
    hit_d       = hit_i;
    pend_d      = hit_i & ~hit_q & strobe_en_i;
    pend_page_d = pend_page_q;
    pend_data_d = pend_data_q;
    if (pend_d) begin
      pend_page_d = io_page_i;
      pend_data_d = wr_data_i;
    end
    regs_d = regs_q;
    if (init_load_i) begin
      for (int p = 0; p < PAGES; p++) begin
        regs_d[p] = SEG_W'(PAGES - 1 - p) & mask;
      end
    end else if (pend_q) begin
      regs_d[pend_page_q] = pend_data_q & mask;
    end
  end

  // Commit report, IO readback (unused high bits read as 1) and memory lookup.
  always_comb begin
    cmt_o                  = pend_q;
    cmt_page_o             = pend_page_q;
    cmt_seg_o              = pend_data_q & mask;
    rd_data_o              = 8'hFF;
    rd_data_o[SEG_W-1:0]   = regs_q[io_page_i] | ~mask;
    seg_o                  = regs_q[mem_page_i] & mask;
  end

  // Channel state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hit_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_page_q <= '0;
      pend_data_q <= '0;
      regs_q      <= '0;
    end else begin
      hit_q       <= hit_d;
      pend_q      <= pend_d;
      pend_page_q <= pend_page_d;
      pend_data_q <= pend_data_d;
      regs_q      <= regs_d;
    end
  end

endmodule

// File: rtl/msx_mapper_bank.sv
// MSX memory-mapper bank: CHANNELS independent mappers (ports FC-FF), an
// initialisation sequence, and a latest-wins segment-change notification
// with an ascending queue for simultaneous commits.
// Build option: define MSX_MAPPER_READBACK_EN to enable IO readback
// (q/output_rq); otherwise the mapper is write-only (q=FF, output_rq=0).
// Supported ranges: CHANNELS 1..8, SEG_W 1..8.
module msx_mapper_bank
  import msx_mapper_bank_pkg::*;
#(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned SEG_W    = 8
) (
  input logic               clk,
  input logic               reset_n,
  msx_mapper_bank_if.slave  bus
);

  logic [CHANNELS-1:0]            cmt;
  logic [CHANNELS-1:0][1:0]       cmt_page;
  logic [CHANNELS-1:0][SEG_W-1:0] cmt_seg;
  logic [CHANNELS-1:0][7:0]       rd_data;
  logic [CHANNELS-1:0][SEG_W-1:0] seg;
  upd_t                           cmt_entry [CHANNELS];

  map_state_e          state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  upd_t                upd_q, upd_d;
  logic [CHANNELS-1:0] qv_q, qv_d;
  upd_t                qe_q [CHANNELS];
  upd_t                qe_d [CHANNELS];

  logic       cmt_any, pop_any;
  logic [2:0] cmt_lo, pop_lo;
  upd_t       cmt_first, pop_first;
  logic       unused_bits;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    msx_mapper_chan #(
      .SEG_W (SEG_W)
    ) u_chan (
      .clk         (clk),
      .reset_n     (reset_n),
      .hit_i       (bus.ch_sel[c] & bus.io_en & bus.wr),
      .strobe_en_i (~busy_q),
      .init_load_i ((state_q == StInit) && (idx_q == 3'(c))),
      .io_page_i   (bus.addr[1:0]),
      .wr_data_i   (bus.data_in[SEG_W-1:0]),
      .size_log2_i (bus.size_log2[c]),
      .mem_page_i  (bus.addr[15:14]),
      .cmt_o       (cmt[c]),
      .cmt_page_o  (cmt_page[c]),
      .cmt_seg_o   (cmt_seg[c]),
      .rd_data_o   (rd_data[c]),
      .seg_o       (seg[c])
    );
    assign cmt_entry[c] = '{ch: 3'(c), page: cmt_page[c], seg: MAX_SEG_W'(cmt_seg[c])};
  end

  assign unused_bits = ^{bus.addr, bus.data_in, upd_q.seg};

  // Memory-side segment lookup; channels beyond CHANNELS read as segment 0.
  always_comb begin
    bus.seg_out = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.mem_ch == 3'(i)) bus.seg_out = seg[i];
    end
  end

`ifdef MSX_MAPPER_READBACK_EN
  logic [7:0] rd_and;

  // Hit channels are ANDed onto the read bus, as on a shared open-drain bus.
  always_comb begin
    rd_and = 8'hFF;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.ch_sel[i]) rd_and = rd_and & rd_data[i];
    end
    bus.q         = rd_and;
    bus.output_rq = bus.io_en & bus.rd & (|bus.ch_sel);
  end
`else
  logic unused_rd;

  assign bus.q         = 8'hFF;
  assign bus.output_rq = 1'b0;
  assign unused_rd     = ^{bus.rd, rd_data};
`endif

  // Lowest-index committing channel and lowest-index queued notification.
  always_comb begin
    cmt_any   = 1'b0;
    cmt_lo    = '0;
    cmt_first = '0;
    pop_any   = 1'b0;
    pop_lo    = '0;
    pop_first = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (cmt[i]) begin
        cmt_any   = 1'b1;
        cmt_lo    = 3'(i);
        cmt_first = cmt_entry[i];
      end
      if (qv_q[i]) begin
        pop_any   = 1'b1;
        pop_lo    = 3'(i);
        pop_first = qe_q[i];
      end
    end
  end

  // FSM next state: INIT walks the channels; otherwise a new commit always
  // takes the notification slot, extra commits queue, accepts pop the queue.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    upd_d   = upd_q;
    qv_d    = qv_q;
    qe_d    = qe_q;
    if (state_q == StInit) begin
      if (idx_q == 3'(CHANNELS - 1)) begin
        state_d = StIdle;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end else begin
      if (valid_q && bus.upd_ready) valid_d = 1'b0;
      if (cmt_any) begin
        valid_d = 1'b1;
        upd_d   = cmt_first;
        for (int i = 0; i < CHANNELS; i++) begin
          if (cmt[i]) begin
            if (3'(i) == cmt_lo) begin
              qv_d[i] = 1'b0;
            end else begin
              qv_d[i] = 1'b1;
              qe_d[i] = cmt_entry[i];
            end
          end
        end
      end else if (!valid_d && pop_any) begin
        valid_d = 1'b1;
        upd_d   = pop_first;
        for (int i = 0; i < CHANNELS; i++) begin
          if (3'(i) == pop_lo) qv_d[i] = 1'b0;
        end
      end
      if (!valid_d) begin
        state_d = StIdle;
      end else if (|qv_d) begin
        state_d = StCommit;
      end else begin
        state_d = StNotify;
      end
    end
    busy_d = (state_d == StInit);
  end

  // FSM and notification registers; reset aborts everything and reruns INIT.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StInit;
      idx_q   <= '0;
      busy_q  <= 1'b1;
      valid_q <= 1'b0;
      upd_q   <= '0;
      qv_q    <= '0;
      for (int i = 0; i < CHANNELS; i++) qe_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      upd_q   <= upd_d;
      qv_q    <= qv_d;
      qe_q    <= qe_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.upd_valid = valid_q;
  assign bus.upd_ch    = upd_q.ch;
  assign bus.upd_page  = upd_q.page;
  assign bus.upd_seg   = upd_q.seg[SEG_W-1:0];

endmodule

// File: doc/msx_mapper_bank.md
MSX_MAPPER_BANK -- requirements
Module: msx_mapper_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 3: number of independent mapper channels (1..8).
REQ-002 SHALL have parameter SEG_W, default 8: segment register width; segment count 2^SIZE_LOG2 never exceeds 2^SEG_W.
REQ-003 SHALL have ports clk (in, 1: system clock) and reset_n (in, 1: synchronous, active-low reset); all state changes on rising clk edge.
REQ-004 SHALL have ports io_en (in, 1: iorq && ~m1), rd (in, 1) and wr (in, 1).
REQ-005 SHALL have ports addr (in, 16: CPU address) and data_in (in, 8: CPU write data).
REQ-006 SHALL have port ch_sel (in, CHANNELS: per-channel IO decode hit for ports FC-FF).
REQ-007 SHALL have port size_log2 (in, CHANNELS x 4: per-channel log2 of segment count, 0..SEG_W).
REQ-008 SHALL have ports mem_ch (in, 3: channel addressed by the memory bus) and seg_out (out, SEG_W: segment for mem_ch at page addr[15:14]).
REQ-009 SHALL have ports q (out, 8: IO read data) and output_rq (out, 1: read request).
REQ-010 SHALL have ports upd_valid (out, 1), upd_ready (in, 1), upd_ch (out, 3), upd_page (out, 2) and upd_seg (out, SEG_W): segment-change notification.
REQ-011 SHALL have port busy (out, 1): high while initialisation runs.

Function
REQ-012 SHALL keep 4 registers per channel, page p selected by addr[1:0] (FC->0 .. FF->3).
REQ-013 SHALL define mask(ch) = 2^size_log2[ch]-1, zero-extended to SEG_W.
REQ-014 SHALL detect a write strobe as the rising edge of (ch_sel[ch] && io_en && wr), registered once per channel; a held wr SHALL commit exactly once.
REQ-015 SHALL commit data_in[SEG_W-1:0] & mask(ch) to the register one cycle after the strobe edge.
REQ-016 SHALL raise upd_valid on the commit cycle, with upd_ch/upd_page/upd_seg equal to the committed values.
REQ-017 SHALL hold upd_valid and its fields until the cycle in which upd_ready is high.
REQ-018 SHALL, on a new commit while upd_valid && !upd_ready, keep upd_valid high and overwrite the fields with the newer commit (latest-wins; older notification dropped).
REQ-019 SHALL, on a commit in the same cycle as acceptance, keep upd_valid high with the new fields.
REQ-020 SHALL, when several channels strobe in the same cycle, commit all registers, notify the lowest channel index, and queue the others one per cycle in ascending order.
REQ-021 SHALL drive output_rq = io_en && rd && |ch_sel, combinationally.
REQ-022 SHALL drive q as the AND over the hit channels of (reg | ~mask), with bits above SEG_W set to 1, and q = FF when no channel is hit.
REQ-023 SHALL drive seg_out = reg[mem_ch][addr[15:14]] & mask(mem_ch) combinationally, and 0 when mem_ch >= CHANNELS.
REQ-024 SHALL apply a changed size_log2 to reads and seg_out immediately; stored bits are not rewritten.
REQ-025 SHALL implement an FSM with states INIT, IDLE, COMMIT and NOTIFY.
REQ-026 SHALL, in INIT, load page p of every channel with 3-p (masked), one channel per cycle, then go to IDLE.
REQ-027 SHALL keep busy high during INIT, ignore write strobes, and not raise upd_valid.

Reset
REQ-028 SHALL, while reset_n is low, set every register to 0, upd_valid=0, upd fields=0, busy=1, state=INIT, and clear the edge detectors.
REQ-029 SHALL, when reset is asserted mid-notification or mid-INIT, abort it and restart INIT after release.

Configuration
REQ-030 SHALL, with MSX_MAPPER_READBACK_EN defined, provide the readback of REQ-021/022.
REQ-031 SHALL, without MSX_MAPPER_READBACK_EN, tie output_rq=0 and q=FF (write-only mapper); everything else is unchanged.

Structure
REQ-032 SHALL take MAX_CHANNELS=8, PAGES=4, the FSM state enum and the notification struct {ch,page,seg} from the shared MSX package.
REQ-033 SHALL use one sub-module, msx_mapper_chan (4 registers, edge detect, mask, readback), instantiated CHANNELS times by a generate loop.

Verification
REQ-034 Release reset, wait for busy low, set size_log2=3, read FC..FF -> q = F8|3, F8|2, F8|1, F8|0, i.e. FB, FA, F9, F8.
REQ-035 Write 0x2D to FE on ch1 with size_log2=3 -> reg = 05, one upd pulse {1,2,05}, and a 5-cycle held wr gives no second commit.
REQ-036 With upd_ready=0, write FC=1 then FD=2 -> upd_valid held with {ch,1,02}, and exactly one accept when upd_ready=1.
REQ-037 Strobe ch0 and ch2 in the same cycle -> upd {0,..} is accepted first, then {2,..} next cycle.
REQ-038 With mem_ch=1, addr=0x8000 and FE=07 -> seg_out=07; changing size_log2 to 2 gives seg_out=03.
REQ-039 Build without MSX_MAPPER_READBACK_EN and read FC -> output_rq=0, q=FF; assert reset mid-INIT -> registers 0, then INIT reruns.
